// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the CPU cycle controller
//
// Purpose: state encoding and default counter width shared by
//          cpu_cycle_controller and its bench.
// Ports:   none (package).
package cpu_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enabled modulo-2^W counter with sticky wrap flag
//
// Purpose: counts cycles where en is high; ovf is set on the all-ones -> 0
//          wrap and stays set until reset.
// Ports:   clk, reset (async, active-high), en (count enable),
//          count [W-1:0] (current value), ovf (sticky wrap flag).
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         ovf
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      count <= count + W'(1);
      if (count == {W{1'b1}}) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_cycle_controller.sv
// rtl/cpu_cycle_controller.sv - run/step/halt/resume sequencer for the core cycle enable
//
// Purpose: drives the processor cycle enable for a programmed number of
//          cycles, single steps, halts and resumes, and counts enabled cycles.
// Ports:   clk, reset (async, active-high);
//          start + run_cycles [CNT_W-1:0], step, halt, resume (requests);
//          cpu_en (core enable), busy (RUN/STEP), halted (HALTED),
//          done (one-cycle end pulse), cycle_count [CNT_W-1:0] (wrapping
//          enabled-cycle total), cnt_ovf (sticky wrap flag).
module cpu_cycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             step,
  input  logic             halt,
  input  logic             resume,
  output logic             cpu_en,
  output logic             busy,
  output logic             halted,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             cnt_ovf
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             from_halted, from_halted_nxt;
  logic             done_nxt;

  always_comb begin
    state_nxt       = state;
    remaining_nxt   = remaining;
    from_halted_nxt = from_halted;
    done_nxt        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (run_cycles != '0) begin
            state_nxt     = ST_RUN;
            remaining_nxt = run_cycles;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (step) begin
          state_nxt       = ST_STEP;
          from_halted_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        // RUN is only entered with remaining >= 1, so this cannot underflow.
        remaining_nxt = remaining - CNT_W'(1);
        if (halt) begin
          // A halt on the last cycle parks with remaining = 0; resume then ends the run.
          state_nxt = ST_HALTED;
        end else if (remaining == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      ST_STEP: begin
        state_nxt = from_halted ? ST_HALTED : ST_IDLE;
        done_nxt  = 1'b1;
      end
      ST_HALTED: begin
        if (start) begin
          remaining_nxt = run_cycles;
          if (run_cycles != '0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else if (resume) begin
          if (remaining != '0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else if (step) begin
          state_nxt       = ST_STEP;
          from_halted_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe and never glitch between edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      from_halted <= 1'b0;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      from_halted <= from_halted_nxt;
      cpu_en      <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      busy        <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      halted      <= (state_nxt == ST_HALTED);
      done        <= done_nxt;
    end
  end

  // The count advances at the end of every cycle in which the core was enabled.
  wrap_counter #(
    .W(CNT_W)
  ) u_cycle_counter (
    .clk  (clk),
    .reset(reset),
    .en   (cpu_en),
    .count(cycle_count),
    .ovf  (cnt_ovf)
  );

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// tb/tb_cpu_cycle_controller.sv - self-checking bench for cpu_cycle_controller
module tb_cpu_cycle_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] run_cycles;
  logic        step;
  logic        halt;
  logic        resume;
  logic        cpu_en, busy, halted, done, cnt_ovf;
  logic [15:0] cycle_count;

  logic        start4;
  logic [3:0]  run4;
  logic        zero4;
  logic        cpu_en4, busy4, halted4, done4, ovf4;
  logic [3:0]  count4;

  int vectors;
  int miscompares;

  cpu_cycle_controller #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .step(step), .halt(halt), .resume(resume),
    .cpu_en(cpu_en), .busy(busy), .halted(halted), .done(done),
    .cycle_count(cycle_count), .cnt_ovf(cnt_ovf)
  );

  cpu_cycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .run_cycles(run4),
    .step(zero4), .halt(zero4), .resume(zero4),
    .cpu_en(cpu_en4), .busy(busy4), .halted(halted4), .done(done4),
    .cycle_count(count4), .cnt_ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] rc;
    logic        step;
    logic        halt;
    logic        resume;
    logic        en;
    logic        busy;
    logic        halted;
    logic        done;
    logic [15:0] count;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic s, logic [15:0] rc, logic st, logic h, logic r,
                              logic e, logic b, logic hd, logic d, logic [15:0] c);
    vec_t v;
    v.start = s; v.rc = rc; v.step = st; v.halt = h; v.resume = r;
    v.en = e; v.busy = b; v.halted = hd; v.done = d; v.count = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    start = 1'b0; run_cycles = '0; step = 1'b0; halt = 1'b0; resume = 1'b0;
    start4 = 1'b0; run4 = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    chk("reset_outputs", {cpu_en, busy, halted, done, cnt_ovf, cycle_count}, 32'h0);
    reset = 1'b0;
  endtask

  // Runs until done is seen (bounded), counting enabled cycles and done pulses.
  task automatic run_and_count(input int bound, output int n_en, output int n_done,
                               output int overlap);
    n_en = 0; n_done = 0; overlap = 0;
    for (int i = 0; i < bound && n_done == 0; i++) begin
      if (cpu_en) n_en++;
      if (done) n_done++;
      if (cpu_en && done) overlap++;
      tick();
    end
  endtask

  int n_en, n_done, overlap;

  initial begin
    vectors = 0;
    miscompares = 0;
    zero4 = 1'b0;
    do_reset();

    //          start rc  step halt res | en busy hlt done count
    tbl[0]  = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 0, 16'd0);
    tbl[1]  = mk(1, 16'd5, 0, 0, 0,  1, 1, 0, 0, 16'd0);
    tbl[2]  = mk(0, 16'd0, 0, 0, 0,  1, 1, 0, 0, 16'd1);
    tbl[3]  = mk(0, 16'd0, 1, 0, 0,  1, 1, 0, 0, 16'd2);
    tbl[4]  = mk(1, 16'd9, 0, 0, 0,  1, 1, 0, 0, 16'd3);
    tbl[5]  = mk(0, 16'd0, 0, 0, 0,  1, 1, 0, 0, 16'd4);
    tbl[6]  = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 1, 16'd5);
    tbl[7]  = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 0, 16'd5);
    tbl[8]  = mk(0, 16'd0, 1, 0, 0,  1, 1, 0, 0, 16'd5);
    tbl[9]  = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 1, 16'd6);
    tbl[10] = mk(0, 16'd0, 1, 0, 0,  1, 1, 0, 0, 16'd6);
    tbl[11] = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 1, 16'd7);
    tbl[12] = mk(1, 16'd0, 0, 0, 0,  0, 0, 0, 1, 16'd7);
    tbl[13] = mk(0, 16'd0, 0, 1, 1,  0, 0, 0, 0, 16'd7);
    tbl[14] = mk(1, 16'd2, 1, 0, 0,  1, 1, 0, 0, 16'd7);
    tbl[15] = mk(0, 16'd0, 0, 0, 0,  1, 1, 0, 0, 16'd8);
    tbl[16] = mk(0, 16'd0, 0, 0, 0,  0, 0, 0, 1, 16'd9);

    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; run_cycles = tbl[i].rc; step = tbl[i].step;
      halt = tbl[i].halt; resume = tbl[i].resume;
      tick();
      chk($sformatf("vec%0d", i),
          {12'h0, cpu_en, busy, halted, done, cycle_count},
          {12'h0, tbl[i].en, tbl[i].busy, tbl[i].halted, tbl[i].done, tbl[i].count});
    end
    clear_inputs();

    // Halt on the 8th enabled cycle of a 21-cycle run, step while halted, resume.
    do_reset();
    start = 1'b1; run_cycles = 16'd21; tick(); clear_inputs();
    for (int i = 0; i < 7; i++) tick();
    chk("pre_halt_count", {cpu_en, cycle_count}, {1'b1, 16'd7});
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halted_state", {cpu_en, busy, halted, done, cycle_count}, {4'b0010, 16'd8});
    step = 1'b1; tick(); step = 1'b0;
    chk("halted_step_en", {cpu_en, busy, halted, done}, 4'b1100);
    tick();
    chk("halted_step_back", {cpu_en, busy, halted, done, cycle_count}, {4'b0011, 16'd9});
    resume = 1'b1; tick(); resume = 1'b0;
    run_and_count(40, n_en, n_done, overlap);
    chk("resume_en_cycles", n_en, 13);
    chk("resume_done", n_done, 1);
    chk("resume_overlap", overlap, 0);
    chk("resume_final", {done, halted, cycle_count}, {2'b00, 16'd22});

    // Halt coinciding with the last cycle: resume ends immediately.
    do_reset();
    start = 1'b1; run_cycles = 16'd3; tick(); clear_inputs();
    tick(); tick();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("last_halt", {cpu_en, halted, done, cycle_count}, {3'b010, 16'd3});
    resume = 1'b1; tick(); resume = 1'b0;
    chk("last_resume", {cpu_en, busy, halted, done, cycle_count}, {4'b0001, 16'd3});
    tick();
    chk("last_resume_after", {cpu_en, done, cycle_count}, {2'b00, 16'd3});

    // Asynchronous reset in the middle of a 10-cycle run.
    do_reset();
    start = 1'b1; run_cycles = 16'd10; tick(); clear_inputs();
    tick(); tick(); tick();
    chk("mid_run_count", {cpu_en, cycle_count}, {1'b1, 16'd3});
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", {cpu_en, busy, halted, done, cnt_ovf, cycle_count}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("no_done_after_reset", {done, cpu_en}, 2'b00);
    start = 1'b1; run_cycles = 16'd4; tick(); clear_inputs();
    run_and_count(20, n_en, n_done, overlap);
    chk("post_reset_en", n_en, 4);
    chk("post_reset_done", n_done, 1);
    chk("post_reset_count", cycle_count, 16'd4);

    // Counter wrap on the 4-bit instance.
    do_reset();
    start4 = 1'b1; run4 = 4'd15; tick(); clear_inputs();
    begin
      int e4, d4;
      e4 = 0; d4 = 0;
      for (int i = 0; i < 30 && d4 == 0; i++) begin
        if (cpu_en4) e4++;
        if (done4) d4++;
        tick();
      end
      chk("wrap_en", e4, 15);
      chk("wrap_done", d4, 1);
    end
    chk("wrap_15", {ovf4, count4}, {1'b0, 4'd15});
    start4 = 1'b1; run4 = 4'd2; tick(); clear_inputs();
    chk("wrap_start", {ovf4, count4}, {1'b0, 4'd15});
    tick();
    chk("wrap_0", {ovf4, count4}, {1'b1, 4'd0});
    tick();
    chk("wrap_1", {done4, ovf4, count4}, {2'b11, 4'd1});
    tick();
    chk("wrap_sticky", {done4, ovf4, count4}, {2'b01, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
